// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the MMIO bridge: address map,
// CTRL bit positions and timer FSM encoding.
package mmio_bridge_pkg;

    localparam logic [31:0] DM_LIMIT   = 32'h0000_3000;
    localparam logic [31:0] TIMER_BASE = 32'h0000_7F00;
    localparam logic [31:0] LED_ADDR   = 32'h0000_7F10;
    localparam logic [31:0] SW_ADDR    = 32'h0000_7F14;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_t;

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU data port and data-memory port bundled together;
// the bridge is the slave, the CPU/memory side is the master.
interface mmio_bridge_if;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, dm_rdata,
        output cpu_rdata, dm_addr, dm_wdata, dm_we
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, dm_rdata,
        input  cpu_rdata, dm_addr, dm_wdata, dm_we
    );

endinterface

// File: rtl/mmio_bridge_timer.sv
// Programmable countdown timer: CTRL/PRESET/COUNT registers,
// IDLE/LOAD/CNT/INT sequencer and sticky interrupt flag.
module mmio_timer
    import mmio_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_t  state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = sel && we && (offset == OFF_CTRL);
    assign wr_preset = sel && we && (offset == OFF_PRESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_preset)
                preset <= wdata;
            if (wr_ctrl || wr_preset)
                irq_flag <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN])
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count <= 32'd1) begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                ST_INT: begin
                    if (ctrl[CTRL_MODE+:2] == MODE_RELOAD) begin
                        state <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // a CPU store to CTRL overrides the one-shot auto-disable
            if (wr_ctrl)
                ctrl <= wdata[3:0];
        end
    end

    always_comb begin
        rdata = 32'd0;
        unique case (offset)
            OFF_CTRL:   rdata = {28'd0, ctrl};
            OFF_PRESET: rdata = preset;
            OFF_COUNT:  rdata = count;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_flag && ctrl[CTRL_IM];

endmodule

// File: rtl/mmio_bridge.sv
// Address decoder between the CPU data port and data memory,
// timer, LED register and synchronized switches.
module mmio_bridge
    import mmio_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mmio_bridge_if.slave bus,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out,
    output logic        irq
);

    logic [31:0] word;
    logic        dm_hit;
    logic        tmr_hit;
    logic        led_hit;
    logic        sw_hit;
    logic [31:0] tmr_rdata;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic        unused_byte_sel;

    assign word    = {bus.cpu_addr[31:2], 2'b00};
    assign unused_byte_sel = ^bus.cpu_addr[1:0];
    assign dm_hit  = word < DM_LIMIT;
    assign tmr_hit = word[31:4] == TIMER_BASE[31:4];
    assign led_hit = word == LED_ADDR;
    assign sw_hit  = word == SW_ADDR;

    assign bus.dm_addr  = bus.cpu_addr;
    assign bus.dm_wdata = bus.cpu_wdata;
    assign bus.dm_we    = bus.cpu_we && dm_hit;

    mmio_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .sel    (tmr_hit),
        .we     (bus.cpu_we),
        .offset (word[3:2]),
        .wdata  (bus.cpu_wdata),
        .rdata  (tmr_rdata),
        .irq    (irq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= 8'd0;
            sw_meta <= 8'd0;
            sw_sync <= 8'd0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (bus.cpu_we && led_hit)
                led_out <= bus.cpu_wdata[7:0];
        end
    end

    always_comb begin
        bus.cpu_rdata = 32'd0;
        unique case (1'b1)
            dm_hit:  bus.cpu_rdata = bus.dm_rdata;
            tmr_hit: bus.cpu_rdata = tmr_rdata;
            led_hit: bus.cpu_rdata = {24'd0, led_out};
            sw_hit:  bus.cpu_rdata = {24'd0, sw_sync};
            default: bus.cpu_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: decode, timer modes,
// switch sync, LED register and async reset.
module tb_mmio_bridge;
    import mmio_bridge_pkg::*;

    localparam logic [31:0] A_CTRL   = TIMER_BASE;
    localparam logic [31:0] A_PRESET = TIMER_BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = TIMER_BASE + 32'h8;

    logic       clk;
    logic       rst;
    logic [7:0] sw_in;
    logic [7:0] led_out;
    logic       irq;
    int         n_chk;
    int         n_pass;

    mmio_bridge_if bus ();

    mmio_bridge dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sw_in   (sw_in),
        .led_out (led_out),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_we = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        bus.cpu_addr = a;
        bus.cpu_we   = 1'b0;
        #1;
        chk(tag, bus.cpu_rdata, exp);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        sw_in = 8'h00;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.cpu_we = 1'b0;
        bus.dm_rdata = 32'd0;
        #3;
        chk("rst_led", {24'd0, led_out}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_dm_we", {31'd0, bus.dm_we}, 32'h0);
        #9 rst = 1'b0;
        tick();
        chk_rd("rst_ctrl", A_CTRL, 32'h0);
        chk_rd("rst_count", A_COUNT, 32'h0);

        // switch synchronizer: two edges of latency
        sw_in = 8'hA5;
        tick();
        chk_rd("sw_1edge", SW_ADDR, 32'h0);
        tick();
        chk_rd("sw_2edge", SW_ADDR, 32'hA5);

        wr(LED_ADDR, 32'h1FF);
        chk("led_out", {24'd0, led_out}, 32'hFF);
        chk_rd("led_rd", LED_ADDR, 32'hFF);

        // data memory pass-through and unmapped space
        tick();
        bus.cpu_addr = 32'h10;
        bus.cpu_wdata = 32'hDEADBEEF;
        bus.cpu_we = 1'b1;
        #1;
        chk("dm_we", {31'd0, bus.dm_we}, 32'h1);
        chk("dm_addr", bus.dm_addr, 32'h10);
        chk("dm_wdata", bus.dm_wdata, 32'hDEADBEEF);
        bus.cpu_we = 1'b0;
        bus.dm_rdata = 32'h1234;
        #1;
        chk("dm_rd", bus.cpu_rdata, 32'h1234);
        bus.cpu_addr = 32'h7F20;
        bus.cpu_we = 1'b1;
        #1;
        chk("unm_we", {31'd0, bus.dm_we}, 32'h0);
        chk("unm_rd", bus.cpu_rdata, 32'h0);
        bus.cpu_addr = DM_LIMIT - 32'd4;
        #1;
        chk("dm_top_we", {31'd0, bus.dm_we}, 32'h1);
        bus.cpu_addr = DM_LIMIT;
        #1;
        chk("dm_lim_we", {31'd0, bus.dm_we}, 32'h0);
        bus.cpu_we = 1'b0;
        tick();
        chk("led_keep", {24'd0, led_out}, 32'hFF);

        // one-shot, PRESET=3
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        chk_rd("os_c3", A_COUNT, 32'd3);
        tick();
        chk_rd("os_c2", A_COUNT, 32'd2);
        tick();
        chk_rd("os_c1", A_COUNT, 32'd1);
        chk("os_irq_e4", {31'd0, irq}, 32'h0);
        tick();
        chk_rd("os_c0", A_COUNT, 32'd0);
        chk("os_irq_e5", {31'd0, irq}, 32'h1);
        tick();
        chk_rd("os_ctrl", A_CTRL, 32'h8);
        tick();
        tick();
        chk("os_irq_hold", {31'd0, irq}, 32'h1);
        wr(A_CTRL, 32'h8);
        chk("os_irq_clr", {31'd0, irq}, 32'h0);

        // PRESET=0 and same-edge collisions
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        chk("p0_irq_e2", {31'd0, irq}, 32'h0);
        wr(A_CTRL, 32'h9);
        chk("set_wins", {31'd0, irq}, 32'h1);
        wr(A_CTRL, 32'h9);
        chk_rd("cpu_wins", A_CTRL, 32'h9);
        chk("cpu_wins_irq", {31'd0, irq}, 32'h0);
        wr(A_CTRL, 32'h0);
        tick();
        tick();
        tick();
        chk("p0_stop_irq", {31'd0, irq}, 32'h0);

        // auto-reload, PRESET=2: flag every 4 edges
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        tick();
        tick();
        tick();
        chk("ar_irq_e3", {31'd0, irq}, 32'h0);
        chk_rd("ar_c1", A_COUNT, 32'd1);
        tick();
        chk("ar_irq_e4", {31'd0, irq}, 32'h1);
        wr(A_CTRL, 32'hB);
        chk("ar_irq_clr", {31'd0, irq}, 32'h0);
        tick();
        chk_rd("ar_reload", A_COUNT, 32'd2);
        tick();
        chk("ar_irq_e7", {31'd0, irq}, 32'h0);
        tick();
        chk("ar_irq_e8", {31'd0, irq}, 32'h1);
        wr(A_CTRL, 32'h3);
        chk("ar_im0_clr", {31'd0, irq}, 32'h0);
        tick();
        chk_rd("ar_im0_c2", A_COUNT, 32'd2);
        tick();
        tick();
        chk_rd("ar_im0_c0", A_COUNT, 32'd0);
        chk("ar_im0_irq", {31'd0, irq}, 32'h0);
        tick();
        tick();
        chk_rd("ar_im0_rl", A_COUNT, 32'd2);
        wr(A_CTRL, 32'h0);
        tick();
        tick();

        // disable mid-count, PRESET written during CNT
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h1);
        repeat (5) tick();
        chk_rd("dis_c7", A_COUNT, 32'd7);
        wr(A_PRESET, 32'd20);
        chk_rd("preset_mid", A_COUNT, 32'd6);
        wr(A_CTRL, 32'h0);
        chk_rd("dis_c5", A_COUNT, 32'd5);
        repeat (3) tick();
        chk_rd("dis_hold", A_COUNT + 32'd1, 32'd5);
        chk("dis_irq", {31'd0, irq}, 32'h0);
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h1);
        tick();
        tick();
        chk_rd("reen_c10", A_COUNT, 32'd10);
        wr(A_CTRL, 32'h0);
        tick();

        // async reset in CNT with irq high
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        repeat (6) tick();
        chk_rd("pre_rst_c2", A_COUNT, 32'd2);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'h0);
        chk("arst_led", {24'd0, led_out}, 32'h0);
        chk_rd("arst_count", A_COUNT, 32'd0);
        #1 rst = 1'b0;
        tick();
        chk_rd("arst_ctrl", A_CTRL, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the single-cycle CPU's data port: consumes its data address, store data and write strobe, and returns load data to the CPU's `Data_in`.
- Decodes each access to one of four targets: external data memory, an internal programmable countdown timer, an LED output register, or a synchronized switch input.
- Drives a timer interrupt line toward a future CP0 block.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address above the data-memory window (window is 0 .. DM_LIMIT-1).
- TIMER_BASE, 32'h0000_7F00, base of timer registers: CTRL +0, PRESET +4, COUNT +8.
- LED_ADDR, 32'h0000_7F10, LED output register.
- SW_ADDR, 32'h0000_7F14, switch input register (read-only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  byte address from CPU ALU result.
- cpu_wdata  in  32  store data from CPU.
- cpu_we  in  1  store strobe from CPU.
- cpu_rdata  out  32  load data to CPU.
- dm_addr  out  32  address to data memory (equals cpu_addr).
- dm_wdata  out  32  store data to data memory (equals cpu_wdata).
- dm_we  out  1  data-memory write enable.
- dm_rdata  in  32  read data from data memory.
- sw_in  in  8  asynchronous board switches.
- led_out  out  8  LED register contents.
- irq  out  1  timer interrupt request.

Behaviour:
- Reset (async, rst=1) sets the following:
  - CTRL=0, PRESET=0, COUNT=0, LED=0, sync flops=0, irq_flag=0.
  - Timer state=IDLE.
  - Outputs: led_out=0, irq=0, dm_we=0.
- Decode uses word addressing; cpu_addr[1:0] is ignored. Accesses are word-only.
- Reads are combinational in the same cycle, matching the single-cycle CPU:
  - DM range returns dm_rdata.
  - CTRL returns {28'b0, CTRL[3:0]}.
  - PRESET and COUNT return the full 32-bit register.
  - LED returns {24'b0, LED}.
  - SW returns {24'b0, sw_sync}.
  - Unmapped addresses return 0.
- Writes take effect at the clock edge:
  - dm_we = cpu_we AND addr in the DM window.
  - Writes to COUNT, SW or unmapped addresses are ignored.
- sw_in passes through a 2-flop synchronizer, so reads reflect a value from 2 edges earlier.
- CTRL bits:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - [3] IM, the interrupt mask.
- Timer FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: when EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT frozen.
    - Else if COUNT<=1, COUNT <= 0, irq_flag <= 1, go to INT.
    - Else COUNT <= COUNT-1.
  - INT:
    - One-shot: CTRL.EN <= 0, go to IDLE.
    - Auto-reload: go to LOAD.
- irq = irq_flag AND CTRL.IM (combinational from registers).
- irq_flag clears on any CPU write to CTRL or PRESET.
- A flag set and a clear in the same cycle resolve to set; the event is never lost.
- A CPU write to CTRL in the same cycle that INT clears EN: the CPU value wins.
- A PRESET write during CNT does not disturb COUNT; it is used at the next LOAD.
- PRESET=0 or 1 both reach INT on the first CNT cycle.
- A mid-count reset returns to IDLE immediately, with irq low.

Decomposition:
- Shared package holds:
  - Address constants: DM_LIMIT, TIMER_BASE, offsets, LED_ADDR, SW_ADDR.
  - CTRL bit-position constants.
  - 2-bit FSM state encoding.
- One sub-module, `mmio_timer`, contains the CTRL/PRESET/COUNT registers, the FSM and irq_flag. It has a simple register port: sel, we, offset, wdata, rdata.
- Decode, the LED register and the synchronizer stay in `mmio_bridge`.

Test Plan:
- DM pass-through:
  - Stimulus: write addr 0x0000_0010, data 0xDEADBEEF, we=1.
  - Required: dm_we=1, dm_addr=0x10. With dm_rdata=0x1234 on a read, cpu_rdata=0x1234.
  - Stimulus: write to 0x7F20.
  - Required: dm_we=0, cpu_rdata=0.
- One-shot timer:
  - Stimulus: PRESET=3, then CTRL=0x9 (EN, mode 0, IM).
  - Required: irq rises 5 edges after the CTRL-write edge. COUNT reads 3,2,1,0 on the intermediate cycles. CTRL reads 0x8 afterward.
  - Required: irq stays high until a CTRL write, which drops it at that edge.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Required: irq_flag sets every 4 cycles (LOAD, CNT, CNT, INT).
  - Required: with IM=0 (CTRL=0x3), irq stays 0 while COUNT keeps cycling.
- Disable mid-count:
  - Stimulus: PRESET=10, CTRL=0x1, then CTRL=0x0 when COUNT=6.
  - Required: COUNT holds at 5 or 6 per edge timing, state IDLE, irq=0.
  - Stimulus: re-enable.
  - Required: reloads from 10.
- Switch/LED:
  - Stimulus: sw_in=0xA5.
  - Required: read of SW_ADDR returns 0xA5 no earlier than the 2nd edge.
  - Stimulus: write LED_ADDR data 0x1FF.
  - Required: led_out=0xFF.
- Async reset:
  - Stimulus: assert rst between edges during CNT with irq high.
  - Required: irq=0, led_out=0, COUNT=0 immediately without a clock edge.
